// File: rtl/obstacle_pkg.sv
// ============================================================================
// Module   : obstacle_pkg
// Brief    : Buzzer level codes shared by the obstacle-alert tile.
// Revision : 1.0
// ============================================================================
`default_nettype none

package obstacle_pkg;

    typedef logic [1:0] buzz_lvl_t;

    localparam buzz_lvl_t LVL_OFF  = 2'b00;
    localparam buzz_lvl_t LVL_ALL  = 2'b01;
    localparam buzz_lvl_t LVL_NEAR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/sensor_debounce.sv
// ============================================================================
// Module   : sensor_debounce
// Brief    : Two-flop synchroniser plus counter debouncer for one sensor bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sensor_debounce #(
    parameter int DEB_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic sensor_i,
    output logic s_db_o
);

    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          s_db_q;
    logic          s_db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Accept on the cycle the run would reach DEB_CYCLES; agreement wipes any partial run.
    always_comb begin
        s_db_d = s_db_q;
        cnt_d  = '0;
        if (sync2_q != s_db_q) begin
            if (cnt_q == CNT_LAST) begin
                s_db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            s_db_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (ena) begin
            sync1_q <= sensor_i;
            sync2_q <= sync1_q;
            s_db_q  <= s_db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_db_o = s_db_q;

endmodule

`default_nettype wire

// File: rtl/obstacle_alert.sv
// ============================================================================
// Module   : obstacle_alert
// Brief    : Debounced multi-channel obstacle classifier with steady/pulsed buzzers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module obstacle_alert
    import obstacle_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int DEB_CYCLES  = 8,
    parameter int BEEP_PERIOD = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [CHANNELS-1:0]   sensor,
    input  logic                  mode,
    output logic [2*CHANNELS-1:0] buzz_level,
    output logic [CHANNELS-1:0]   buzz_drive,
    output logic                  near_any,
    output logic                  near_all
);

    localparam int            BW        = $clog2(BEEP_PERIOD);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_PERIOD - 1);
    localparam logic [BW-1:0] BEEP_HALF = BW'(BEEP_PERIOD / 2);

    logic [CHANNELS-1:0]   s_db;
    logic [2*CHANNELS-1:0] level_q;
    logic [2*CHANNELS-1:0] level_d;
    logic [BW-1:0]         beep_q;
    logic [BW-1:0]         beep_d;
    logic                  any_on;
    logic                  phase;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        sensor_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .ena      (ena),
            .sensor_i (sensor[gi]),
            .s_db_o   (s_db[gi])
        );
    end

    // An obstacle on one side lights the buzzer on the opposite side.
    always_comb begin
        level_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (&s_db) begin
                level_d[2*i +: 2] = LVL_ALL;
            end else if (s_db[CHANNELS-1-i]) begin
                level_d[2*i +: 2] = LVL_NEAR;
            end else begin
                level_d[2*i +: 2] = LVL_OFF;
            end
        end
    end

    assign any_on = |level_q;
    assign beep_d = !any_on            ? '0 :
                    (beep_q == BEEP_LAST) ? '0 : beep_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            beep_q  <= '0;
        end else if (ena) begin
            level_q <= level_d;
            beep_q  <= beep_d;
        end
    end

    assign phase = (beep_q < BEEP_HALF);

    always_comb begin
        buzz_drive = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (level_q[2*i +: 2])
                LVL_ALL:  buzz_drive[i] = 1'b1;
                LVL_NEAR: buzz_drive[i] = mode ? phase : 1'b1;
                default:  buzz_drive[i] = 1'b0;
            endcase
        end
    end

    assign buzz_level = level_q;
    assign near_any   = |s_db;
    assign near_all   = &s_db;

endmodule

`default_nettype wire

// File: tb/tb_obstacle_alert.sv
// ============================================================================
// Module   : tb_obstacle_alert
// Brief    : Self-checking bench for obstacle_alert (2- and 3-channel builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_obstacle_alert;

    localparam int DEB2 = 8;
    localparam int BP2  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       mode = 1'b0;
    logic [1:0] sensor2 = '0;
    logic [2:0] sensor3 = '0;

    logic [3:0] lvl2;
    logic [1:0] drv2;
    logic       any2, all2;
    logic [5:0] lvl3;
    logic [2:0] drv3;
    logic       any3, all3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    obstacle_alert #(.CHANNELS(2), .DEB_CYCLES(DEB2), .BEEP_PERIOD(BP2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sensor(sensor2), .mode(mode),
        .buzz_level(lvl2), .buzz_drive(drv2), .near_any(any2), .near_all(all2)
    );

    obstacle_alert #(.CHANNELS(3), .DEB_CYCLES(4), .BEEP_PERIOD(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sensor(sensor3), .mode(mode),
        .buzz_level(lvl3), .buzz_drive(drv3), .near_any(any3), .near_all(all3)
    );

    // Reference for the 2-channel build: a value is accepted once the last DEB2
    // synchronised samples all disagree with the accepted value.
    logic [1:0]      m_s1, m_s2, m_db;
    logic [DEB2-1:0] m_win [2];
    logic [3:0]      m_lvl;
    int              m_on;

    function automatic logic [3:0] classify(input logic [1:0] db);
        if (db == 2'b11) return 4'b0101;
        return {db[0] ? 2'b10 : 2'b00, db[1] ? 2'b10 : 2'b00};
    endfunction

    function automatic logic [1:0] exp_drive(input logic [3:0] lvl, input int on, input logic md);
        logic [1:0] d;
        logic       ph;
        ph = (on % BP2) < (BP2 / 2);
        for (int i = 0; i < 2; i++) begin
            case (lvl[2*i +: 2])
                2'b01:   d[i] = 1'b1;
                2'b10:   d[i] = md ? ph : 1'b1;
                default: d[i] = 1'b0;
            endcase
        end
        return d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= '0; m_s2 <= '0; m_db <= '0; m_lvl <= '0; m_on <= 0;
            for (int c = 0; c < 2; c++) m_win[c] <= '0;
        end else if (ena) begin
            m_s1 <= sensor2;
            m_s2 <= m_s1;
            for (int c = 0; c < 2; c++) begin
                if ({m_win[c][DEB2-2:0], m_s2[c]} == {DEB2{~m_db[c]}}) begin
                    m_db[c]  <= ~m_db[c];
                    m_win[c] <= {DEB2{~m_db[c]}};
                end else begin
                    m_win[c] <= {m_win[c][DEB2-2:0], m_s2[c]};
                end
            end
            m_lvl <= classify(m_db);
            m_on  <= (m_lvl != 4'b0000) ? m_on + 1 : 0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; sensor2 = '0; sensor3 = '0; mode = 1'b0; ena = 1'b1;
        cycles(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; sensor2 = 2'b11; sensor3 = 3'b111; ena = 1'b1; mode = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        n_cmp++; if (lvl2 !== 4'b0000) begin n_err++; $display("FAIL reset_lvl2: got %b want 0000", lvl2); end
        n_cmp++; if (drv2 !== 2'b00) begin n_err++; $display("FAIL reset_drv2: got %b want 00", drv2); end
        n_cmp++; if ({any2, all2} !== 2'b00) begin n_err++; $display("FAIL reset_flags2: got %b want 00", {any2, all2}); end
        n_cmp++; if ({lvl3, drv3, any3, all3} !== 11'b0) begin n_err++; $display("FAIL reset_dut3: got %b want 0", {lvl3, drv3, any3, all3}); end
    endtask

    task automatic test_single_side();
        apply_reset();
        sensor2 = 2'b01;
        cycles(9);
        n_cmp++; if (any2 !== 1'b0) begin n_err++; $display("FAIL single_any_early: got %b want 0", any2); end
        cycles(1);
        n_cmp++; if (any2 !== 1'b1) begin n_err++; $display("FAIL single_any_edge10: got %b want 1", any2); end
        n_cmp++; if (lvl2 !== 4'b0000) begin n_err++; $display("FAIL single_lvl_edge10: got %b want 0000", lvl2); end
        cycles(1);
        n_cmp++; if (lvl2 !== 4'b1000) begin n_err++; $display("FAIL single_lvl_edge11: got %b want 1000", lvl2); end
        for (int k = 0; k < 20; k++) begin
            n_cmp++; if (drv2 !== 2'b10) begin n_err++; $display("FAIL single_drive_steady k=%0d: got %b want 10", k, drv2); end
            cycles(1);
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        sensor2 = 2'b10;
        cycles(5);
        sensor2 = 2'b00;
        for (int k = 0; k < 20; k++) begin
            n_cmp++; if ({any2, lvl2} !== 5'b0) begin n_err++; $display("FAIL glitch k=%0d: got any=%b lvl=%b want 0", k, any2, lvl2); end
            cycles(1);
        end
    endtask

    task automatic test_pulsed();
        apply_reset();
        mode = 1'b1; sensor2 = 2'b01;
        cycles(11);
        for (int k = 0; k < 32; k++) begin
            n_cmp++;
            if (drv2 !== (((k % 16) < 8) ? 2'b10 : 2'b00)) begin
                n_err++; $display("FAIL pulse k=%0d: got %b want %b", k, drv2, ((k % 16) < 8) ? 2'b10 : 2'b00);
            end
            if (k == 12) begin
                mode = 1'b0; #1;
                n_cmp++; if (drv2 !== 2'b10) begin n_err++; $display("FAIL mode_comb: got %b want 10", drv2); end
                mode = 1'b1;
            end
            cycles(1);
        end
        sensor2 = 2'b00;
        cycles(12);
        n_cmp++; if ({lvl2, drv2} !== 6'b0) begin n_err++; $display("FAIL pulse_release: got lvl=%b drv=%b want 0", lvl2, drv2); end
        sensor2 = 2'b01;
        cycles(11);
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (drv2 !== ((k < 8) ? 2'b10 : 2'b00)) begin
                n_err++; $display("FAIL pulse_restart k=%0d: got %b want %b", k, drv2, (k < 8) ? 2'b10 : 2'b00);
            end
            cycles(1);
        end
    endtask

    task automatic test_all_near();
        apply_reset();
        sensor2 = 2'b11;
        cycles(10);
        n_cmp++; if (lvl2 !== 4'b0000) begin n_err++; $display("FAIL all_no_near_step: got %b want 0000", lvl2); end
        cycles(1);
        n_cmp++; if (lvl2 !== 4'b0101) begin n_err++; $display("FAIL all_lvl: got %b want 0101", lvl2); end
        n_cmp++; if ({any2, all2} !== 2'b11) begin n_err++; $display("FAIL all_flags: got %b want 11", {any2, all2}); end
        for (int k = 0; k < 40; k++) begin
            mode = (k >= 20);
            #1;
            n_cmp++; if (drv2 !== 2'b11) begin n_err++; $display("FAIL all_drive k=%0d: got %b want 11", k, drv2); end
            cycles(1);
        end
    endtask

    task automatic test_three_channel();
        apply_reset();
        sensor3 = 3'b010;
        cycles(5);
        n_cmp++; if (any3 !== 1'b0) begin n_err++; $display("FAIL ch3_any_early: got %b want 0", any3); end
        cycles(1);
        n_cmp++; if (any3 !== 1'b1) begin n_err++; $display("FAIL ch3_any: got %b want 1", any3); end
        cycles(1);
        n_cmp++; if (lvl3 !== 6'b001000) begin n_err++; $display("FAIL ch3_lvl: got %b want 001000", lvl3); end
        n_cmp++; if (drv3 !== 3'b010) begin n_err++; $display("FAIL ch3_drv: got %b want 010", drv3); end
        apply_reset();
        sensor3 = 3'b001;
        cycles(4);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        cycles(5);
        n_cmp++; if (any3 !== 1'b0) begin n_err++; $display("FAIL ch3_midreset_early: got %b want 0", any3); end
        cycles(1);
        n_cmp++; if (any3 !== 1'b1) begin n_err++; $display("FAIL ch3_midreset_accept: got %b want 1", any3); end
        cycles(1);
        n_cmp++; if ({lvl3, drv3} !== 9'b100000_100) begin n_err++; $display("FAIL ch3_midreset_lvl: got lvl=%b drv=%b want 100000/100", lvl3, drv3); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({lvl2, drv2, any2, all2} !== {m_lvl, exp_drive(m_lvl, m_on, mode), |m_db, &m_db}) begin
                n_err++;
                $display("FAIL random k=%0d: got lvl=%b drv=%b any=%b all=%b want lvl=%b drv=%b any=%b all=%b",
                         k, lvl2, drv2, any2, all2, m_lvl, exp_drive(m_lvl, m_on, mode), |m_db, &m_db);
            end
            if ($urandom_range(0, 11) == 0) sensor2 = 2'($urandom);
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) mode = ~mode;
        end
        ena = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_side();
        test_glitch();
        test_pulsed();
        test_all_near();
        test_three_channel();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
